// File: rtl/video_timing_gen_if.sv
// Video timing bundle: raster position, blanking/sync flags, strobes and the
// pixel data path that passes through the timing generator.
interface video_timing_gen_if #(
    parameter int HC_W  = 9,
    parameter int VC_W  = 8,
    parameter int RGB_W = 24
);
    logic [RGB_W-1:0] rgbin;
    logic [RGB_W-1:0] rgbout;
    logic [HC_W-1:0]  hcnt;
    logic [VC_W-1:0]  vcnt;
    logic             hb;
    logic             vb;
    logic             hs;
    logic             vs;
    logic             de;
    logic             line_start;
    logic             frame_start;

    // timing generator side
    modport master (
        input  rgbin,
        output rgbout, hcnt, vcnt, hb, vb, hs, vs, de, line_start, frame_start
    );

    // video pipeline / display side
    modport slave (
        output rgbin,
        input  rgbout, hcnt, vcnt, hb, vb, hs, vs, de, line_start, frame_start
    );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters advanced by ce_pix, registered
// blanking/sync flags derived from next-state counters (zero lag against the
// counters), line/frame start strobes, and de-gated pixel data.
module video_timing_gen #(
    parameter int H_TOTAL    = 318,
    parameter int H_ACTIVE   = 256,
    parameter int HS_START   = 283,
    parameter int HS_END     = 303,
    parameter int V_TOTAL    = 256,
    parameter int V_ACTIVE   = 240,
    parameter int VS_START   = 251,
    parameter int VS_END     = 254,
    parameter int HS_ACT_LOW = 1,
    parameter int VS_ACT_LOW = 1,
    parameter int RGB_W      = 24,
    localparam int HC_W      = $clog2(H_TOTAL),
    localparam int VC_W      = $clog2(V_TOTAL)
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ce_pix,
    input  logic [3:0]  mask_cols,
    video_timing_gen_if.master vid
);

    // Reject illegal timing sets while elaborating.
    if (!(H_ACTIVE <= HS_START && HS_START < HS_END && HS_END <= H_TOTAL)) begin : g_bad_h
        $error("video_timing_gen: illegal horizontal timing parameters");
    end
    if (!(V_ACTIVE <= VS_START && VS_START < VS_END && VS_END <= V_TOTAL)) begin : g_bad_v
        $error("video_timing_gen: illegal vertical timing parameters");
    end

    localparam logic [HC_W-1:0] H_LAST = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0] V_LAST = VC_W'(V_TOTAL - 1);
    // Compares run at 32 bits so limits equal to 2**W do not truncate.
    localparam logic [31:0] HA  = 32'(H_ACTIVE);
    localparam logic [31:0] HSS = 32'(HS_START);
    localparam logic [31:0] HSE = 32'(HS_END);
    localparam logic [31:0] VA  = 32'(V_ACTIVE);
    localparam logic [31:0] VSS = 32'(VS_START);
    localparam logic [31:0] VSE = 32'(VS_END);
    localparam logic HS_OFF = (HS_ACT_LOW != 0);
    localparam logic VS_OFF = (VS_ACT_LOW != 0);

    logic [HC_W-1:0] hcnt, hcnt_nxt;
    logic [VC_W-1:0] vcnt, vcnt_nxt;
    logic [3:0]      mask, mask_nxt;
    logic            h_last, v_last;
    logic            hb, vb, hs, vs, de;
    logic            hb_nxt, vb_nxt, hs_nxt, vs_nxt;
    logic            line_start, frame_start;
    logic [31:0]     hn, vn, mn;

    // Next counter state and the flags that will match it once loaded.
    always_comb begin
        h_last   = (hcnt == H_LAST);
        v_last   = (vcnt == V_LAST);
        hcnt_nxt = h_last ? '0 : hcnt + 1'b1;
        vcnt_nxt = vcnt;
        if (h_last) vcnt_nxt = v_last ? '0 : vcnt + 1'b1;
        // The column mask only changes at a line boundary.
        mask_nxt = h_last ? mask_cols : mask;
        hn       = 32'(hcnt_nxt);
        vn       = 32'(vcnt_nxt);
        mn       = 32'(mask_nxt);
        hb_nxt   = (hn < mn) || (hn >= HA);
        vb_nxt   = (vn >= VA);
        hs_nxt   = ((hn >= HSS) && (hn < HSE)) ? ~HS_OFF : HS_OFF;
        vs_nxt   = ((vn >= VSS) && (vn < VSE)) ? ~VS_OFF : VS_OFF;
    end

    // Counters, mask and flags advance together on each pixel enable.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hcnt <= H_LAST;
            vcnt <= V_LAST;
            mask <= '0;
            hb   <= 1'b1;
            vb   <= 1'b1;
            de   <= 1'b0;
            hs   <= HS_OFF;
            vs   <= VS_OFF;
        end else if (ce_pix) begin
            hcnt <= hcnt_nxt;
            vcnt <= vcnt_nxt;
            mask <= mask_nxt;
            hb   <= hb_nxt;
            vb   <= vb_nxt;
            de   <= ~hb_nxt & ~vb_nxt;
            hs   <= hs_nxt;
            vs   <= vs_nxt;
        end
    end

    // Strobes are per clk_sys cycle, so they drop on the next clock even when ce_pix is idle.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= ce_pix & h_last;
            frame_start <= ce_pix & h_last & v_last;
        end
    end

    assign vid.hcnt        = hcnt;
    assign vid.vcnt        = vcnt;
    assign vid.hb          = hb;
    assign vid.vb          = vb;
    assign vid.hs          = hs;
    assign vid.vs          = vs;
    assign vid.de          = de;
    assign vid.line_start  = line_start;
    assign vid.frame_start = frame_start;
    assign vid.rgbout      = de ? vid.rgbin : '0;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default-timing instance for horizontal timing, hold, reset
// and column mask; a small-raster instance (active-high syncs) for full-frame
// vertical timing, de counting and whole-line masking.
module tb_video_timing_gen;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       ce_pix, ce_sm;
    logic [3:0] mask_cols, mask_sm;
    int         errors = 0;
    int         checks = 0;
    int         eh, ev, em;

    typedef struct {
        string      name;
        int         adv;    // ce_pix pulses before the check
        bit         b2b;    // 1: ce_pix every cycle, 0: every 2nd cycle
        int         h;
        int         v;
        logic [6:0] fl;     // {hb, vb, hs, vs, de, line_start, frame_start}
    } vec_t;

    vec_t vt[12];

    video_timing_gen_if #(.HC_W(9), .VC_W(8), .RGB_W(24)) vif ();
    video_timing_gen_if #(.HC_W(5), .VC_W(4), .RGB_W(8))  sif ();

    video_timing_gen dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ce_pix    (ce_pix),
        .mask_cols (mask_cols),
        .vid       (vif)
    );

    video_timing_gen #(
        .H_TOTAL(20), .H_ACTIVE(12), .HS_START(14), .HS_END(17),
        .V_TOTAL(10), .V_ACTIVE(6),  .VS_START(7),  .VS_END(9),
        .HS_ACT_LOW(0), .VS_ACT_LOW(0), .RGB_W(8)
    ) dut_sm (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ce_pix    (ce_sm),
        .mask_cols (mask_sm),
        .vid       (sif)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] main_act();
        return 64'({vif.hcnt, vif.vcnt, vif.hb, vif.vb, vif.hs, vif.vs, vif.de,
                    vif.line_start, vif.frame_start, vif.rgbout});
    endfunction

    function automatic logic [63:0] main_exp(input int h, input int v, input logic [6:0] fl);
        return 64'({9'(h), 8'(v), fl, fl[2] ? 24'hFFFFFF : 24'h0});
    endfunction

    function automatic logic [63:0] sm_act();
        return 64'({sif.hcnt, sif.vcnt, sif.hb, sif.vb, sif.hs, sif.vs, sif.de,
                    sif.line_start, sif.frame_start, sif.rgbout});
    endfunction

    // One clk_sys cycle with the given enable; sample 1 time unit after the edge.
    task automatic tick(input logic ce);
        ce_pix = ce;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic adv(input int n, input bit b2b);
        for (int i = 0; i < n; i++) begin
            if (!b2b) tick(1'b0);
            tick(1'b1);
        end
    endtask

    task automatic run_vec(input vec_t t);
        adv(t.adv, t.b2b);
        chk(t.name, main_act(), main_exp(t.h, t.v, t.fl));
    endtask

    // One full small-raster frame against an independent position model.
    task automatic run_small(input logic [3:0] m, input int exp_de);
        int  cnt;
        bit  hb, vb, hs, vs, de, ls, fs;
        cnt     = 0;
        mask_sm = m;
        for (int c = 0; c < 200; c++) begin
            ce_sm = 1'b1;
            @(posedge clk_sys);
            #1;
            if (eh == 19) begin
                em = m;
                eh = 0;
                ev = (ev == 9) ? 0 : ev + 1;
            end else begin
                eh = eh + 1;
            end
            hb = (eh < em) || (eh >= 12);
            vb = (ev >= 6);
            hs = (eh >= 14) && (eh < 17);
            vs = (ev >= 7) && (ev < 9);
            de = !hb && !vb;
            ls = (eh == 0);
            fs = (eh == 0) && (ev == 0);
            chk("sm_px", sm_act(),
                64'({5'(eh), 4'(ev), hb, vb, hs, vs, de, ls, fs, de ? 8'hA5 : 8'h00}));
            if (sif.de) cnt++;
        end
        ce_sm = 1'b0;
        chk("sm_de_count", 64'(cnt), 64'(exp_de));
    endtask

    initial begin
        vt[0]  = '{"h1",        1,   1'b0, 1,   0, 7'b0011100};
        vt[1]  = '{"h255",      254, 1'b0, 255, 0, 7'b0011100};
        vt[2]  = '{"h256_blank",1,   1'b0, 256, 0, 7'b1011000};
        vt[3]  = '{"hs_first",  27,  1'b0, 283, 0, 7'b1001000};
        vt[4]  = '{"hs_last",   19,  1'b0, 302, 0, 7'b1001000};
        vt[5]  = '{"hs_off",    1,   1'b0, 303, 0, 7'b1011000};
        vt[6]  = '{"h317",      14,  1'b0, 317, 0, 7'b1011000};
        vt[7]  = '{"line1",     1,   1'b0, 0,   1, 7'b0011110};
        vt[8]  = '{"l1_end",    317, 1'b1, 317, 1, 7'b1011000};
        vt[9]  = '{"line2_b2b", 1,   1'b1, 0,   2, 7'b0011110};
        vt[10] = '{"l2_h1_b2b", 1,   1'b1, 1,   2, 7'b0011100};
        vt[11] = '{"l2_h150",   149, 1'b1, 150, 2, 7'b0011100};

        reset_n   = 1'b1;
        ce_pix    = 1'b0;
        ce_sm     = 1'b0;
        mask_cols = 4'd0;
        mask_sm   = 4'd0;
        vif.rgbin = 24'hFFFFFF;
        sif.rgbin = 8'hA5;
        eh = 19; ev = 9; em = 0;

        #2 reset_n = 1'b0;
        @(posedge clk_sys);
        #1;
        chk("reset_main", main_act(), main_exp(317, 255, 7'b1111000));
        chk("reset_sm", sm_act(), 64'({5'd19, 4'd9, 7'b1100000, 8'h00}));
        reset_n = 1'b1;

        // Small raster: full frames with no mask, mask == H_ACTIVE, mask 3.
        run_small(4'd0, 72);
        run_small(4'd12, 0);
        run_small(4'd3, 54);

        // Main: idle after reset holds state, first pulse loads (0,0) with strobes.
        tick(1'b0); tick(1'b0); tick(1'b0);
        chk("idle_after_reset", main_act(), main_exp(317, 255, 7'b1111000));
        tick(1'b1);
        chk("first_pulse", main_act(), main_exp(0, 0, 7'b0011111));
        tick(1'b0);
        chk("strobe_drop", main_act(), main_exp(0, 0, 7'b0011100));

        for (int i = 0; i < 12; i++) run_vec(vt[i]);

        // Freeze at (150,100) for 50 idle cycles, then resume.
        adv(98 * 318, 1'b1);
        chk("at_150_100", main_act(), main_exp(150, 100, 7'b0011100));
        for (int i = 0; i < 50; i++) begin
            tick(1'b0);
            chk("hold", main_act(), main_exp(150, 100, 7'b0011100));
        end
        tick(1'b1);
        chk("resume", main_act(), main_exp(151, 100, 7'b0011100));

        // Asynchronous reset between clock edges.
        ce_pix = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        chk("async_reset", main_act(), main_exp(317, 255, 7'b1111000));
        @(posedge clk_sys);
        #3 reset_n = 1'b1;
        @(posedge clk_sys);
        #1;
        tick(1'b0);
        tick(1'b1);
        chk("after_reset_frame", main_act(), main_exp(0, 0, 7'b0011111));

        // Column mask: loaded at line start, mid-line changes wait for the next line.
        ce_pix = 1'b0;
        reset_n = 1'b0;
        mask_cols = 4'd5;
        #3 reset_n = 1'b1;
        @(posedge clk_sys);
        #1;
        run_vec('{"mask_h0",   1,   1'b1, 0,   0, 7'b1011011});
        run_vec('{"mask_h4",   4,   1'b1, 4,   0, 7'b1011000});
        run_vec('{"mask_h5",   1,   1'b1, 5,   0, 7'b0011100});
        run_vec('{"mask_h100", 95,  1'b1, 100, 0, 7'b0011100});
        mask_cols = 4'd0;
        run_vec('{"mask_h317", 217, 1'b1, 317, 0, 7'b1011000});
        run_vec('{"unmask_l1", 1,   1'b1, 0,   1, 7'b0011110});
        mask_cols = 4'd7;
        run_vec('{"l1_h3",     3,   1'b1, 3,   1, 7'b0011100});
        run_vec('{"mask7_l2",  315, 1'b1, 0,   2, 7'b1011010});
        run_vec('{"mask7_h6",  6,   1'b1, 6,   2, 7'b1011000});
        run_vec('{"mask7_h7",  1,   1'b1, 7,   2, 7'b0011100});
        ce_pix = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
